// File: rtl/vmc_pkg.sv
// rtl/vmc_pkg.sv - shared burst encodings, address/data word field map and FSM states
package vmc_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;

  localparam int ADR_MSB = 35;
  localparam int ADR_LSB = 6;
  localparam int WE_BIT  = 5;
  localparam int BTE_MSB = 4;
  localparam int BTE_LSB = 3;
  localparam int CTI_MSB = 2;
  localparam int CTI_LSB = 0;
  localparam int DAT_MSB = 35;
  localparam int DAT_LSB = 4;
  localparam int SEL_MSB = 3;
  localparam int SEL_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADR  = 3'd1,
    ST_CMD  = 3'd2,
    ST_WRD  = 3'd3,
    ST_WDV  = 3'd4
  } state_t;

  // Classic cycles and linear bursts move a single word.
  function automatic logic [4:0] burst_len(input logic [2:0] cti, input logic [1:0] bte);
    if (cti == CTI_CLASSIC || bte == BTE_LINEAR) return 5'd1;
    case (bte)
      BTE_WRAP4: return 5'd4;
      BTE_WRAP8: return 5'd8;
      default:   return 5'd16;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant searching upward from the last grant with wrap
module rr_arbiter #(
  parameter int N = 3,
  parameter int W = 2
) (
  input  logic [0:N-1] i_req,
  input  logic [W-1:0] i_last,
  output logic [0:N-1] o_gnt,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!o_any && i_req[(int'(i_last) + k) % N]) begin
        o_any = 1'b1;
        o_gnt[(int'(i_last) + k) % N] = 1'b1;
        o_idx = W'((int'(i_last) + k) % N);
      end
    end
  end

endmodule

// File: rtl/egress_arbiter.sv
// rtl/egress_arbiter.sv - drains egress queues one transaction at a time into command and write-data streams
module egress_arbiter
  import vmc_pkg::*;
#(
  parameter int nr_of_wb_ports = 3,
  parameter int port_w         = 2
) (
  input  logic                      sdram_clk,
  input  logic                      sdram_rst,
  input  logic [0:nr_of_wb_ports-1] fifo_empty,
  input  logic [0:nr_of_wb_ports-1] fifo_flag,
  input  logic [35:0]               fifo_dat_i,
  output logic                      fifo_rd_adr,
  output logic                      fifo_rd_data,
  output logic [0:nr_of_wb_ports-1] fifo_re,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic                      cmd_we,
  output logic [29:0]               cmd_adr,
  output logic [1:0]                cmd_bte,
  output logic [4:0]                cmd_len,
  output logic [port_w-1:0]         cmd_port,
  output logic                      wr_valid,
  input  logic                      wr_ready,
  output logic [31:0]               wr_dat,
  output logic [3:0]                wr_sel
);

  state_t                    r_state, w_next;
  logic [port_w-1:0]         r_port, r_last;
  logic [4:0]                r_cnt;
  logic                      r_first;
  logic [31:0]               r_wr_dat;
  logic [3:0]                r_wr_sel;
  logic [0:nr_of_wb_ports-1] w_req, w_gnt, w_re;
  logic [port_w-1:0]         w_idx;
  logic                      w_any, w_rd_adr, w_rd_data;

  assign w_req = fifo_flag & ~fifo_empty;

  rr_arbiter #(.N(nr_of_wb_ports), .W(port_w)) u_rr (
    .i_req  (w_req),
    .i_last (r_last),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  always_ff @(posedge sdram_clk or posedge sdram_rst) begin
    if (sdram_rst) r_state <= ST_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_re      = '0;
    w_rd_adr  = 1'b0;
    w_rd_data = 1'b0;
    case (r_state)
      ST_IDLE: if (w_any) begin
        w_re     = w_gnt;
        w_rd_adr = 1'b1;
        w_next   = ST_ADR;
      end
      ST_ADR: w_next = ST_CMD;
      ST_CMD: if (cmd_ready) w_next = cmd_we ? ST_WRD : ST_IDLE;
      ST_WRD: begin
        for (int i = 0; i < nr_of_wb_ports; i++) w_re[i] = (i == int'(r_port));
        w_rd_data = 1'b1;
        w_next    = ST_WDV;
      end
      ST_WDV: if (wr_ready) w_next = (r_cnt == 5'd1) ? ST_IDLE : ST_WRD;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sdram_clk or posedge sdram_rst) begin
    if (sdram_rst) begin
      cmd_adr  <= '0;
      cmd_we   <= 1'b0;
      cmd_bte  <= '0;
      cmd_len  <= '0;
      cmd_port <= '0;
      r_port   <= '0;
      r_last   <= port_w'(nr_of_wb_ports - 1);
      r_cnt    <= '0;
      r_first  <= 1'b0;
      r_wr_dat <= '0;
      r_wr_sel <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_any) r_port <= w_idx;
        ST_ADR: begin
          cmd_adr  <= fifo_dat_i[ADR_MSB:ADR_LSB];
          cmd_we   <= fifo_dat_i[WE_BIT];
          cmd_bte  <= fifo_dat_i[BTE_MSB:BTE_LSB];
          cmd_len  <= burst_len(fifo_dat_i[CTI_MSB:CTI_LSB], fifo_dat_i[BTE_MSB:BTE_LSB]);
          cmd_port <= r_port;
        end
        ST_CMD: if (cmd_ready) begin
          if (cmd_we) r_cnt  <= cmd_len;
          else        r_last <= r_port;
        end
        ST_WRD: r_first <= 1'b1;
        ST_WDV: begin
          if (r_first) begin
            r_wr_dat <= fifo_dat_i[DAT_MSB:DAT_LSB];
            r_wr_sel <= fifo_dat_i[SEL_MSB:SEL_LSB];
            r_first  <= 1'b0;
          end
          if (wr_ready) begin
            r_cnt <= r_cnt - 5'd1;
            if (r_cnt == 5'd1) r_last <= r_port;
          end
        end
        default: ;
      endcase
    end
  end

  // The head word is only on fifo_dat_i during the first WDV cycle; afterwards the captured copy is shown.
  assign wr_dat       = r_first ? fifo_dat_i[DAT_MSB:DAT_LSB] : r_wr_dat;
  assign wr_sel       = r_first ? fifo_dat_i[SEL_MSB:SEL_LSB] : r_wr_sel;
  assign wr_valid     = (r_state == ST_WDV);
  assign cmd_valid    = (r_state == ST_CMD);
  assign fifo_re      = sdram_rst ? '0 : w_re;
  assign fifo_rd_adr  = sdram_rst ? 1'b0 : w_rd_adr;
  assign fifo_rd_data = sdram_rst ? 1'b0 : w_rd_data;

endmodule

// File: tb/tb_egress_arbiter.sv
// tb/tb_egress_arbiter.sv - randomized scoreboard bench for egress_arbiter
module tb_egress_arbiter;

  localparam int NP = 3;
  localparam int PW = 2;

  logic           sdram_clk, sdram_rst;
  logic [0:NP-1]  fifo_empty, fifo_flag, fifo_re;
  logic [35:0]    fifo_dat_i;
  logic           fifo_rd_adr, fifo_rd_data;
  logic           cmd_valid, cmd_ready, cmd_we;
  logic [29:0]    cmd_adr;
  logic [1:0]     cmd_bte;
  logic [4:0]     cmd_len;
  logic [PW-1:0]  cmd_port;
  logic           wr_valid, wr_ready;
  logic [31:0]    wr_dat;
  logic [3:0]     wr_sel;

  egress_arbiter #(.nr_of_wb_ports(NP), .port_w(PW)) dut (
    .sdram_clk(sdram_clk), .sdram_rst(sdram_rst),
    .fifo_empty(fifo_empty), .fifo_flag(fifo_flag), .fifo_dat_i(fifo_dat_i),
    .fifo_rd_adr(fifo_rd_adr), .fifo_rd_data(fifo_rd_data), .fifo_re(fifo_re),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_adr(cmd_adr),
    .cmd_bte(cmd_bte), .cmd_len(cmd_len), .cmd_port(cmd_port),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_dat(wr_dat), .wr_sel(wr_sel)
  );

  typedef struct {
    logic        we;
    logic [29:0] adr;
    logic [1:0]  bte;
    logic [4:0]  len;
  } cmd_t;

  logic [35:0] fq[NP][$];
  int          txn_cnt[NP];
  cmd_t        exp_cmd[NP][$];
  logic [35:0] exp_dat[NP][$];
  int          grant_log[$];

  int n_chk = 0, n_fail = 0;
  bit cmd_hold = 0, wr_hold = 0, rnd_rdy = 0;

  int          last_g, cur_g, beats_left, beats_done, age, re_pulses, beat_total, mon_a;
  bit          in_prog, exp_rdd, p_cv, p_wv;
  logic [35:0] pend_dat = '0;
  logic [29:0] p_adr;
  logic        p_we;
  logic [1:0]  p_bte;
  logic [4:0]  p_len;
  logic [PW-1:0] p_port;
  logic [31:0] p_dat;
  logic [3:0]  p_sel;
  cmd_t        mon_e;
  logic [35:0] mon_w;

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int exp_len(input logic [2:0] cti, input logic [1:0] bte);
    if (cti == 3'b000 || bte == 2'b00) return 1;
    return 2 << bte;
  endfunction

  task automatic add_txn(input int p, input bit we, input logic [2:0] cti,
                         input logic [1:0] bte, input logic [29:0] adr);
    cmd_t c;
    logic [31:0] d;
    logic [3:0] s;
    c.we = we; c.adr = adr; c.bte = bte; c.len = 5'(exp_len(cti, bte));
    fq[p].push_back({adr, we, bte, cti});
    exp_cmd[p].push_back(c);
    if (we) begin
      for (int i = 0; i < exp_len(cti, bte); i++) begin
        d = $urandom;
        s = 4'($urandom);
        fq[p].push_back({d, s});
        exp_dat[p].push_back({d, s});
      end
    end
    txn_cnt[p]++;
  endtask

  function automatic bit busy();
    busy = in_prog;
    for (int p = 0; p < NP; p++)
      if (txn_cnt[p] > 0 || exp_cmd[p].size() > 0 || exp_dat[p].size() > 0) busy = 1;
  endfunction

  task automatic step();
    @(posedge sdram_clk);
    #2;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int t = 0;
    while (t < budget && busy()) begin
      step();
      t++;
    end
    chk(t < budget, {nm, "_timeout"}, t, budget);
    repeat (2) step();
  endtask

  task automatic check_all_zero(input string nm);
    chk(fifo_re == '0, {nm, "_fifo_re"}, fifo_re, 0);
    chk(fifo_rd_adr == 0 && fifo_rd_data == 0, {nm, "_rd_strobes"}, {fifo_rd_adr, fifo_rd_data}, 0);
    chk(cmd_valid == 0 && cmd_we == 0, {nm, "_cmd_valid_we"}, {cmd_valid, cmd_we}, 0);
    chk(cmd_adr == 0 && cmd_bte == 0 && cmd_len == 0 && cmd_port == 0, {nm, "_cmd_fields"},
        {cmd_adr, cmd_bte, cmd_len, cmd_port}, 0);
    chk(wr_valid == 0 && wr_dat == 0 && wr_sel == 0, {nm, "_wr"}, {wr_valid, wr_dat, wr_sel}, 0);
  endtask

  initial begin
    sdram_clk = 0;
    forever #5 sdram_clk = ~sdram_clk;
  end

  // Queue model: contents and flags become visible just after each rising edge.
  initial begin
    fifo_dat_i = '0;
    fifo_empty = '1;
    fifo_flag  = '0;
    forever begin
      @(posedge sdram_clk);
      #1;
      fifo_dat_i = pend_dat;
      for (int p = 0; p < NP; p++) begin
        fifo_empty[p] = (fq[p].size() == 0);
        fifo_flag[p]  = (txn_cnt[p] > 0);
      end
    end
  end

  initial begin
    cmd_ready = 0;
    wr_ready  = 0;
    forever begin
      @(posedge sdram_clk);
      #1;
      cmd_ready = cmd_hold ? 1'b0 : (rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
      wr_ready  = wr_hold  ? 1'b0 : (rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  // Monitor: reference arbitration plus scoreboard checks at the falling edge.
  initial begin
    last_g = NP - 1; in_prog = 0; age = -1; exp_rdd = 0; p_cv = 0; p_wv = 0;
    beats_left = 0; beats_done = 0; re_pulses = 0; beat_total = 0; cur_g = 0;
    forever begin
      @(negedge sdram_clk);
      if (sdram_rst) begin
        last_g = NP - 1; in_prog = 0; age = -1; exp_rdd = 0; p_cv = 0; p_wv = 0; beats_left = 0;
      end else begin
        if (age >= 0) age++;
        mon_a = -1;
        for (int i = 0; i < NP; i++) if (fifo_re[i]) mon_a = i;
        if (fifo_re != '0 || fifo_rd_adr || fifo_rd_data)
          chk($countones(fifo_re) == 1 && (fifo_rd_adr ^ fifo_rd_data), "strobe_legal",
              {fifo_re, fifo_rd_adr, fifo_rd_data}, 0);
        if (exp_rdd) begin
          chk(fifo_rd_data == 1, "data_read_next_cycle", fifo_rd_data, 1);
          exp_rdd = 0;
        end
        if (fifo_rd_adr && mon_a >= 0) begin
          int g;
          g = -1;
          for (int k = 1; k <= NP; k++)
            if (g < 0 && fifo_flag[(last_g + k) % NP] && !fifo_empty[(last_g + k) % NP]) g = (last_g + k) % NP;
          chk(!in_prog, "no_overlap", in_prog, 0);
          chk(mon_a == g, "rr_grant", mon_a, g);
          cur_g = mon_a; in_prog = 1; age = 0;
          grant_log.push_back(mon_a);
          re_pulses++;
          if (fq[mon_a].size() > 0) pend_dat = fq[mon_a].pop_front();
          else chk(0, "adr_read_empty", mon_a, 0);
          txn_cnt[mon_a]--;
        end
        if (fifo_rd_data && mon_a >= 0) begin
          re_pulses++;
          chk(mon_a == cur_g && beats_left > 0, "data_read_queue", mon_a, cur_g);
          if (fq[mon_a].size() > 0) pend_dat = fq[mon_a].pop_front();
          else chk(0, "data_read_empty", mon_a, 0);
        end
        if (cmd_valid) begin
          if (age >= 0) begin
            chk(age == 2, "cmd_latency", age, 2);
            age = -1;
          end
          if (p_cv)
            chk(cmd_adr == p_adr && cmd_we == p_we && cmd_bte == p_bte && cmd_len == p_len && cmd_port == p_port,
                "cmd_stable", {cmd_adr, cmd_we, cmd_bte, cmd_len}, {p_adr, p_we, p_bte, p_len});
          if (cmd_ready) begin
            if (exp_cmd[cur_g].size() == 0) chk(0, "cmd_unexpected", cmd_adr, 0);
            else begin
              mon_e = exp_cmd[cur_g].pop_front();
              chk(cmd_we == mon_e.we, "cmd_we", cmd_we, mon_e.we);
              chk(cmd_adr == mon_e.adr, "cmd_adr", cmd_adr, mon_e.adr);
              chk(cmd_bte == mon_e.bte, "cmd_bte", cmd_bte, mon_e.bte);
              chk(cmd_len == mon_e.len, "cmd_len", cmd_len, mon_e.len);
              chk(int'(cmd_port) == cur_g, "cmd_port", cmd_port, cur_g);
            end
            if (!cmd_we) begin
              last_g = cur_g; in_prog = 0;
            end else begin
              beats_left = cmd_len; beats_done = 0; exp_rdd = 1;
            end
            p_cv = 0;
          end else begin
            p_cv = 1; p_adr = cmd_adr; p_we = cmd_we; p_bte = cmd_bte; p_len = cmd_len; p_port = cmd_port;
          end
        end else p_cv = 0;
        if (wr_valid) begin
          if (p_wv) chk(wr_dat == p_dat && wr_sel == p_sel, "wr_hold", {wr_dat, wr_sel}, {p_dat, p_sel});
          if (wr_ready) begin
            if (beats_left <= 0 || exp_dat[cur_g].size() == 0) chk(0, "wr_extra_beat", wr_dat, 0);
            else begin
              mon_w = exp_dat[cur_g].pop_front();
              chk({wr_dat, wr_sel} == mon_w, "wr_beat", {wr_dat, wr_sel}, mon_w);
              beats_left--; beats_done++; beat_total++;
              if (beats_left == 0) begin
                last_g = cur_g; in_prog = 0;
              end else exp_rdd = 1;
            end
            p_wv = 0;
          end else begin
            p_wv = 1; p_dat = wr_dat; p_sel = wr_sel;
          end
        end else p_wv = 0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks expected completion", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [29:0] h_adr;
    logic [4:0]  h_len;
    int          h_pulses;
    for (int p = 0; p < NP; p++) txn_cnt[p] = 0;
    sdram_rst = 1;
    add_txn(1, 0, 3'b000, 2'b00, 30'h0000100);
    repeat (3) step();
    check_all_zero("reset");
    sdram_rst = 0;

    wait_done("read", 200);
    chk(grant_log.size() == 1 && grant_log[0] == 1, "read_grant", grant_log.size() > 0 ? grant_log[0] : -1, 1);
    chk(re_pulses == 1, "read_pulses", re_pulses, 1);

    grant_log.delete(); re_pulses = 0; beat_total = 0;
    add_txn(0, 1, 3'b010, 2'b01, 30'($urandom));
    t = 0;
    while (t < 200 && !(in_prog && beats_done == 1)) begin step(); t++; end
    chk(t < 200, "wrap4_beat1_timeout", t, 200);
    wr_hold = 1;
    step();
    p_dat = wr_dat;
    chk(wr_valid == 1, "wrap4_stall_valid", wr_valid, 1);
    repeat (2) begin
      step();
      chk(wr_valid == 1 && wr_dat == p_dat, "wrap4_stall_dat", wr_dat, p_dat);
    end
    wr_hold = 0;
    wait_done("wrap4", 200);
    chk(beat_total == 4, "wrap4_beats", beat_total, 4);
    chk(re_pulses == 5, "wrap4_pulses", re_pulses, 5);

    add_txn(2, 0, 3'b000, 2'b00, 30'($urandom));
    wait_done("q2_read", 200);
    grant_log.delete();
    add_txn(2, 0, 3'b111, 2'b00, 30'($urandom));
    wait_done("wrap_around", 200);
    chk(grant_log.size() == 1 && grant_log[0] == 2, "wrap_around_grant", grant_log.size() > 0 ? grant_log[0] : -1, 2);

    grant_log.delete();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++) add_txn(p, 0, 3'b000, 2'b00, 30'($urandom));
    wait_done("fairness", 400);
    chk(grant_log.size() == 6, "fair_count", grant_log.size(), 6);
    for (int i = 0; i < grant_log.size(); i++) chk(grant_log[i] == i % 3, "fair_order", grant_log[i], i % 3);

    grant_log.delete(); re_pulses = 0;
    cmd_hold = 1;
    add_txn(1, 0, 3'b000, 2'b00, 30'($urandom));
    t = 0;
    while (t < 50 && !cmd_valid) begin step(); t++; end
    chk(t < 50, "bp_cmd_valid_timeout", t, 50);
    add_txn(0, 1, 3'b010, 2'b11, 30'($urandom));
    h_adr = cmd_adr; h_len = cmd_len; h_pulses = re_pulses;
    repeat (10) begin
      step();
      chk(cmd_valid == 1 && cmd_adr == h_adr && cmd_len == h_len, "bp_stable", {cmd_valid, cmd_adr}, {1'b1, h_adr});
    end
    chk(re_pulses == h_pulses, "bp_no_reads", re_pulses, h_pulses);
    cmd_hold = 0;
    wait_done("backpressure", 400);
    chk(grant_log.size() == 2 && grant_log[0] == 1 && grant_log[1] == 0, "bp_grants",
        grant_log.size(), 2);

    add_txn(0, 1, 3'b010, 2'b10, 30'($urandom));
    t = 0;
    while (t < 200 && !(in_prog && beats_done == 2 && wr_valid)) begin step(); t++; end
    chk(t < 200, "rst_mid_timeout", t, 200);
    sdram_rst = 1;
    #1;
    check_all_zero("rst_mid");
    for (int p = 0; p < NP; p++) begin
      fq[p].delete(); exp_cmd[p].delete(); exp_dat[p].delete(); txn_cnt[p] = 0;
    end
    grant_log.delete();
    repeat (2) step();
    add_txn(1, 0, 3'b000, 2'b00, 30'($urandom));
    add_txn(0, 0, 3'b000, 2'b00, 30'($urandom));
    repeat (2) step();
    sdram_rst = 0;
    wait_done("after_reset", 200);
    chk(grant_log.size() == 2 && grant_log[0] == 0, "after_reset_grant", grant_log.size() > 0 ? grant_log[0] : -1, 0);

    rnd_rdy = 1;
    for (int n = 0; n < 40; n++) begin
      add_txn($urandom_range(0, NP - 1), 1'($urandom), 3'($urandom), 2'($urandom), 30'($urandom));
      repeat ($urandom_range(0, 20)) step();
    end
    wait_done("random", 20000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/egress_arbiter.md
EGRESS_ARBITER -- requirements
Module: egress_arbiter

Interface
REQ-001 SHALL have parameter nr_of_wb_ports, default 3, giving the number of egress queues (1..8).
REQ-002 SHALL have parameter port_w, default 2, giving the width of the port index (>= clog2(nr_of_wb_ports)).
REQ-003 SHALL use one clock and an asynchronous, active-high reset: sdram_clk input 1, the sole clock, all state on rising edge; sdram_rst input 1, the reset.
REQ-004 SHALL have the following FIFO-side ports:
- fifo_empty  input  [0:nr_of_wb_ports-1]  per-queue empty.
- fifo_flag  input  [0:nr_of_wb_ports-1]  per-queue complete transaction queued.
- fifo_dat_i  input  36  egress queue head word, valid one cycle after a read strobe.
- fifo_rd_adr  output  1  read address word.
- fifo_rd_data  output  1  read data word.
- fifo_re  output  [0:nr_of_wb_ports-1]  one-hot queue select.
REQ-005 SHALL have the following command-side ports:
- cmd_valid  output  1  command valid.
- cmd_ready  input  1  command accept.
- cmd_we  output  1  write command.
- cmd_adr  output  30  word address, address-word bits 35:6.
- cmd_bte  output  2  burst type.
- cmd_len  output  5  burst length in words, 1..16.
- cmd_port  output  port_w  granted queue.
REQ-006 SHALL have the following write-data ports:
- wr_valid  output  1  write data valid.
- wr_ready  input  1  write data accept.
- wr_dat  output  32  data, data-word bits 35:4.
- wr_sel  output  4  byte select, data-word bits 3:0.

Function
REQ-007 SHALL decode address words as: bit 5 = we, bits 4:3 = bte, bits 2:0 = cti.
REQ-008 SHALL set burst length to 1 if cti = 000 or bte = 00; otherwise 4, 8 or 16 for bte 01, 10 or 11.
REQ-009 SHALL implement the FSM states IDLE, ADR, CMD, WRD and WDV.
REQ-010 In IDLE, eligible queues SHALL be those with fifo_flag=1 and fifo_empty=0; round-robin grant SHALL search from last_grant+1 upward with wrap.
REQ-011 On a grant in IDLE, SHALL pulse fifo_re[g] and fifo_rd_adr for exactly one cycle and go to ADR.
REQ-012 In IDLE with no eligible queue, SHALL hold all strobes low and stay in IDLE.
REQ-013 In ADR, SHALL register cmd_adr, cmd_we, cmd_bte, cmd_len and cmd_port=g from fifo_dat_i, then go to CMD.
REQ-014 In CMD, SHALL hold cmd_valid=1 with stable fields until a cycle where cmd_ready=1.
REQ-015 On command accept, SHALL go to IDLE with last_grant=g if we=0, else go to WRD with remaining count=cmd_len.
REQ-016 In WRD, SHALL pulse fifo_re[g] and fifo_rd_data for one cycle, then go to WDV.
REQ-017 In WDV, SHALL register wr_dat and wr_sel from fifo_dat_i on entry and hold wr_valid=1 until wr_ready=1.
REQ-018 On data accept, SHALL decrement the count; at count 0 it SHALL go to IDLE with last_grant=g, otherwise to WRD.
REQ-019 SHALL give a grant-to-cmd_valid latency of 2 cycles and a peak write throughput of one word per 2 cycles.
REQ-020 SHALL NOT start a transaction while one is in progress; fifo_flag or fifo_empty changes mid-transaction SHALL be ignored.
REQ-021 SHALL never assert more than one fifo_re bit, and SHALL never assert fifo_rd_adr and fifo_rd_data in the same cycle.
REQ-022 cmd_ready=1 outside CMD and wr_ready=1 outside WDV SHALL have no effect.
REQ-023 If cmd_ready and wr_ready are both high, only the one matching the current state SHALL be honoured.

Reset
REQ-024 While sdram_rst=1, SHALL be in IDLE with every output 0, count=0 and last_grant=nr_of_wb_ports-1, so that queue 0 wins first.
REQ-025 Assertion of sdram_rst in any state SHALL abort the transaction immediately; partial bursts are not resumed.

Structure
REQ-026 The cti/bte encodings, address-word field positions and FSM state encodings SHALL live in the shared package vmc_pkg.
REQ-027 The round-robin grant logic SHALL be a sub-module rr_arbiter (request vector plus last_grant in, one-hot grant plus index out).

Verification
REQ-028 Read: queue 1 holds address word adr=0x0000100, we=0, cti=000 -> one fifo_re[1]+fifo_rd_adr pulse, then cmd_valid with cmd_we=0, cmd_len=1, cmd_port=1; return to IDLE after cmd_ready.
REQ-029 Write wrap4: queue 0, we=1, cti=010, bte=01, then 4 data words -> cmd_len=4, then exactly 4 wr_valid beats in queue order; with wr_ready stalled 3 cycles on beat 2, wr_dat is held.
REQ-030 Fairness: all 3 queues flagged continuously with single reads -> grants 0,1,2,0,1,2.
REQ-031 Wrap-around: last_grant=2 and only queue 2 eligible -> queue 2 granted again.
REQ-032 Reset mid-burst: sdram_rst asserted in WDV after beat 2 of a wrap8 write -> all outputs 0 in the same cycle, IDLE after release, next grant queue 0.
REQ-033 Backpressure: cmd_ready held low 10 cycles -> cmd_valid and fields stable, no further fifo_re pulses.
